hazard_detection_unit: RTL

HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

---
 rtl/hazard_detection_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/hazard_detection_unit.sv
// Pipeline hazard control: load-use stall, taken-branch flush and data-memory wait freeze,
// with saturating stall/flush event counters.
module hazard_detection_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ID_EX_MemRead_i,
    input  logic [4:0]  ID_EX_Rt_i,
    input  logic [4:0]  IF_ID_Rs_i,
    input  logic [4:0]  IF_ID_Rt_i,
    input  logic        IF_ID_UseRt_i,
    input  logic        Branch_taken_i,
    input  logic        Dmem_wait_i,
    output logic        PC_Write_o,
    output logic        IF_ID_Write_o,
    output logic        Pipe_Freeze_o,
    output logic        IF_ID_Flush_o,
    output logic        ID_EX_Flush_o,
    output logic        EX_MEM_Flush_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_RSVD       = 2'd3
    } state_t;

    state_t      state_q, state_d, nxt_s;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        hazard_s;
    logic        h_en_s;

    // Load-use hazard; r0 is never a real dependency.
    assign hazard_s = ID_EX_MemRead_i & (ID_EX_Rt_i != 5'd0) &
                      ((ID_EX_Rt_i == IF_ID_Rs_i) | (IF_ID_UseRt_i & (ID_EX_Rt_i == IF_ID_Rt_i)));
    assign h_en_s   = (state_q != ST_LOAD_STALL);

    // Control outputs and next state; a memory wait in any state freezes and lands in MEM_WAIT.
    always_comb begin
        PC_Write_o     = 1'b1;
        IF_ID_Write_o  = 1'b1;
        Pipe_Freeze_o  = 1'b0;
        IF_ID_Flush_o  = 1'b0;
        ID_EX_Flush_o  = 1'b0;
        EX_MEM_Flush_o = 1'b0;
        nxt_s          = ST_RUN;
        if (rst_i) begin
            PC_Write_o     = 1'b0;
            IF_ID_Write_o  = 1'b0;
            IF_ID_Flush_o  = 1'b1;
            ID_EX_Flush_o  = 1'b1;
            EX_MEM_Flush_o = 1'b1;
            nxt_s          = ST_RUN;
        end else if (Dmem_wait_i) begin
            PC_Write_o    = 1'b0;
            IF_ID_Write_o = 1'b0;
            Pipe_Freeze_o = 1'b1;
            nxt_s         = ST_MEM_WAIT;
        end else if (Branch_taken_i) begin
            IF_ID_Flush_o  = 1'b1;
            ID_EX_Flush_o  = 1'b1;
            EX_MEM_Flush_o = 1'b1;
            nxt_s          = ST_RUN;
        end else if (hazard_s && h_en_s) begin
            PC_Write_o    = 1'b0;
            IF_ID_Write_o = 1'b0;
            ID_EX_Flush_o = 1'b1;
            nxt_s         = ST_LOAD_STALL;
        end else begin
            nxt_s = ST_RUN;
        end
        // The unused encoding behaves as RUN but always recovers to RUN.
        state_d = (state_q == ST_RSVD) ? ST_RUN : nxt_s;
    end

    // Saturating event counter next values.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!PC_Write_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (EX_MEM_Flush_o && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
